// File: rtl/acc_serial_tx_if.sv
// Bus between the accumulator side and the serial transmitter.
// Carries the accumulator value, the control word and the transmitter status.
interface acc_serial_tx_if;
    logic [7:0]  ACC_out;
    logic [15:0] control;
    logic        tx;
    logic        busy;
    logic        done;
    logic        overrun;

    // Driver of ACC_out/control (accumulator/controller side).
    modport master (
        output ACC_out,
        output control,
        input  tx,
        input  busy,
        input  done,
        input  overrun
    );

    // The transmitter itself.
    modport slave (
        input  ACC_out,
        input  control,
        output tx,
        output busy,
        output done,
        output overrun
    );
endinterface

// File: rtl/acc_serial_tx.sv
// Accumulator output-port transmitter.
// On control[OUT_BIT] while idle, snapshots ACC_out and sends an async frame:
// start, 8 data bits LSB-first, optional even parity, stop. Line idles high.
// Optional feature macro: ACC_TX_PARITY_EN adds the even-parity bit (11 bit times).
module acc_serial_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned OUT_BIT      = 14
) (
    input  logic               clk,
    input  logic               reset,
    acc_serial_tx_if.slave     bus
);

    localparam int unsigned    BaudW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef ACC_TX_PARITY_EN
        StParity,
`endif
        StStop
    } state_t;

    state_t            state_q;
    logic [BaudW-1:0]  baud_q;
    logic [2:0]        bit_q;
    logic [7:0]        data_q;

    logic req;
    logic bit_end;

    assign req     = bus.control[OUT_BIT];
    assign bit_end = (baud_q == BaudLast);

    // Frame sequencer; every output is registered and set for the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            baud_q      <= '0;
            bit_q       <= '0;
            data_q      <= '0;
            bus.tx      <= 1'b1;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.overrun <= 1'b0;
        end else begin
            bus.done <= 1'b0;

            // Any request seen mid-frame is dropped but remembered until reset.
            if (state_q != StIdle && req) begin
                bus.overrun <= 1'b1;
            end

            // Baud counter only runs inside a frame and wraps at each bit boundary.
            if (state_q != StIdle) begin
                baud_q <= bit_end ? '0 : baud_q + BaudW'(1);
            end

            case (state_q)
                StIdle: begin
                    if (req) begin
                        data_q   <= bus.ACC_out;
                        state_q  <= StStart;
                        bus.tx   <= 1'b0;
                        bus.busy <= 1'b1;
                    end
                end
                StStart: begin
                    if (bit_end) begin
                        state_q <= StData;
                        bit_q   <= '0;
                        bus.tx  <= data_q[0];
                    end
                end
                StData: begin
                    if (bit_end) begin
                        if (bit_q == 3'd7) begin
`ifdef ACC_TX_PARITY_EN
                            state_q <= StParity;
                            bus.tx  <= ^data_q;
`else
                            state_q <= StStop;
                            bus.tx  <= 1'b1;
`endif
                        end else begin
                            bit_q  <= bit_q + 3'd1;
                            bus.tx <= data_q[bit_q + 3'd1];
                        end
                    end
                end
`ifdef ACC_TX_PARITY_EN
                StParity: begin
                    if (bit_end) begin
                        state_q <= StStop;
                        bus.tx  <= 1'b1;
                    end
                end
`endif
                StStop: begin
                    if (bit_end) begin
                        state_q  <= StIdle;
                        bus.tx   <= 1'b1;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= StIdle;
                    baud_q   <= '0;
                    bus.tx   <= 1'b1;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
